// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// debounce window defaults.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } btn_state_e;

    // 10 ms at 27 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/button_debouncer_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer feeding a counter-based
// debounce FSM with registered level, press and release outputs.
//
//   state           | meaning
//   ----------------+-------------------------------------------------
//   ST_RELEASED     | accepted released, waiting for a low sample
//   ST_PRESS_PEND   | low samples seen, counting toward press accept
//   ST_PRESSED      | accepted pressed, waiting for a high sample
//   ST_RELEASE_PEND | high samples seen, counting toward release accept
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (!sync2_q) begin
                    state_d = ST_PRESS_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (sync2_q) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (sync2_q) begin
                    state_d = ST_RELEASE_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASE_PEND: begin
                if (!sync2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_p = rel_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel pushbutton conditioner: raw active-low pins in, clean
// active-high levels plus one-cycle press/release pulses out.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_n,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_n    (btn_n[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .release_p(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a 4-cycle debounce window;
// edge 0 is the first rising edge that samples a new raw value.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release;

    int total = 0;
    int bad   = 0;

    button_debouncer #(
        .N_CH           (2),
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Inputs are changed 1 time unit after an edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        btn_n = 2'b11;
        for (int c = 0; c < 23; c++) begin
            if (c == 3) rst = 1'b0;
            tick();
            total++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                bad++;
                $display("FAIL reset cyc=%0d level=%b press=%b release=%b required all 0",
                         c, btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] exp_level, exp_press;
        for (int e = 0; e <= 7; e++) begin
            btn_n = 2'b10;
            tick();
            exp_level = (e >= 5) ? 2'b01 : 2'b00;
            exp_press = (e == 5) ? 2'b01 : 2'b00;
            total++;
            if (btn_level !== exp_level) begin
                bad++;
                $display("FAIL clean_press_level edge=%0d got=%b exp=%b", e, btn_level, exp_level);
            end
            total++;
            if (btn_press !== exp_press) begin
                bad++;
                $display("FAIL clean_press_pulse edge=%0d got=%b exp=%b", e, btn_press, exp_press);
            end
            total++;
            if (btn_release !== 2'b00) begin
                bad++;
                $display("FAIL clean_press_release edge=%0d got=%b exp=00", e, btn_release);
            end
        end
    endtask

    task automatic test_release();
        logic [1:0] exp_level, exp_rel;
        for (int e = 0; e <= 7; e++) begin
            btn_n = 2'b11;
            tick();
            exp_level = (e >= 5) ? 2'b00 : 2'b01;
            exp_rel   = (e == 5) ? 2'b01 : 2'b00;
            total++;
            if (btn_level !== exp_level) begin
                bad++;
                $display("FAIL release_level edge=%0d got=%b exp=%b", e, btn_level, exp_level);
            end
            total++;
            if (btn_release !== exp_rel) begin
                bad++;
                $display("FAIL release_pulse edge=%0d got=%b exp=%b", e, btn_release, exp_rel);
            end
            total++;
            if (btn_press !== 2'b00) begin
                bad++;
                $display("FAIL release_press edge=%0d got=%b exp=00", e, btn_press);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_level, exp_press;
        for (int e = 0; e <= 11; e++) begin
            btn_n = (e == 3) ? 2'b11 : 2'b10;
            tick();
            exp_level = (e >= 9) ? 2'b01 : 2'b00;
            exp_press = (e == 9) ? 2'b01 : 2'b00;
            total++;
            if (btn_level !== exp_level) begin
                bad++;
                $display("FAIL bounce_level edge=%0d got=%b exp=%b", e, btn_level, exp_level);
            end
            total++;
            if (btn_press !== exp_press) begin
                bad++;
                $display("FAIL bounce_pulse edge=%0d got=%b exp=%b", e, btn_press, exp_press);
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 0; e <= 15; e++) begin
            btn_n = (e < 3) ? 2'b01 : 2'b11;
            tick();
            total++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                bad++;
                $display("FAIL glitch edge=%0d level=%b press=%b release=%b required all 0",
                         e, btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_simultaneous_reset();
        logic [1:0] exp_level, exp_press;
        for (int e = 0; e <= 12; e++) begin
            btn_n = 2'b00;
            rst   = (e == 3);
            tick();
            exp_level = (e >= 9) ? 2'b11 : 2'b00;
            exp_press = (e == 9) ? 2'b11 : 2'b00;
            total++;
            if (btn_level !== exp_level) begin
                bad++;
                $display("FAIL simul_level edge=%0d got=%b exp=%b", e, btn_level, exp_level);
            end
            total++;
            if (btn_press !== exp_press) begin
                bad++;
                $display("FAIL simul_pulse edge=%0d got=%b exp=%b", e, btn_press, exp_press);
            end
            total++;
            if (btn_release !== 2'b00) begin
                bad++;
                $display("FAIL simul_release edge=%0d got=%b exp=00", e, btn_release);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_release();
        test_glitch();
        test_simultaneous_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions raw active-low pushbuttons before they reach the logic-gate and LED blocks.
- Each channel passes through a 2-flop synchronizer, then a counter-based debounce FSM.
- Outputs per channel: a clean active-high level, a one-cycle press pulse and a one-cycle release pulse.
- Sits directly upstream of the gate blocks; their inputs take btn_level, so they no longer invert raw pins.

Parameters:
- N_CH, 2: number of independent button channels.
- DEBOUNCE_CYCLES, 270000: consecutive stable synchronized cycles required to accept a change. This is 10 ms at 27 MHz. Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_n  input  N_CH  raw pushbutton pins; 0 = pressed; asynchronous to clk.
- btn_level  output  N_CH  debounced state; 1 = pressed.
- btn_press  output  N_CH  one-cycle pulse on accepted press.
- btn_release  output  N_CH  one-cycle pulse on accepted release.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state:
  - Synchronizer flops = 1 (released).
  - Counters = 0.
  - FSM = RELEASED.
  - btn_level, btn_press, btn_release = 0.
  - Reset has priority over all other activity, including mid-count; any partial count is discarded.
- Synchronizer: ff1 <= btn_n[i]; s <= ff1. Only s feeds the FSM.
- FSM per channel, states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND:
  - RELEASED: s=0 -> PRESS_PEND, cnt=1. Otherwise stay, cnt=0.
  - PRESS_PEND:
    - s=1 -> RELEASED, cnt=0 (bounce; no output change).
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, btn_level=1, btn_press=1 for this one cycle.
    - Otherwise cnt++.
  - PRESSED: mirrors RELEASED with s=1 -> RELEASE_PEND, cnt=1.
  - RELEASE_PEND: mirrors PRESS_PEND.
    - s=0 -> PRESSED, cnt=0.
    - On accept: -> RELEASED, btn_level=0, btn_release=1 for one cycle.
- Latency: btn_level and the matching pulse update on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge at which the new raw value is sampled. Raw must be held stable throughout.
- Glitch rejection: any excursion that yields fewer than DEBOUNCE_CYCLES consecutive stable s samples produces no level change and no pulse. The count restarts from zero after each bounce.
- Pulses:
  - btn_press and btn_release are never both 1 on one channel in the same cycle.
  - Each pulse lasts exactly 1 cycle.
  - btn_level changes only on the same edge as its pulse.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
- Button held through reset: after rst deasserts, ff1 samples 0 at edge 1. Press is accepted at edge DEBOUNCE_CYCLES+2.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Outputs are registered; no combinational path from btn_n to any output.

Decomposition:
- Shared include button_pkg.vh holds:
  - FSM state localparams ST_RELEASED=2'd0, ST_PRESS_PEND=2'd1, ST_PRESSED=2'd2, ST_RELEASE_PEND=2'd3.
  - Default DEBOUNCE_CYCLES value.
  - Simulation override value SIM_DEBOUNCE_CYCLES=4.
- Sub-module debounce_channel: one synchronizer, counter and FSM, with ports clk, rst, btn_n, level, press, release.
- The top module instantiates debounce_channel N_CH times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, N_CH=2; edge 0 = first edge sampling the new raw value):
- Reset:
  - Stimulus: rst=1 for 3 cycles, btn_n=2'b11, then rst=0 and hold 20 cycles.
  - Required: btn_level=00 and all pulses 00 at every cycle.
- Clean press:
  - Stimulus: btn_n[0] 1->0 at edge 0, held low.
  - Required: btn_level[0]=1 and btn_press[0]=1 at edge 5 only. btn_press[0]=0 at edge 6. Channel 1 stays 0.
- Bounce:
  - Stimulus: btn_n[0] low edges 0-2, high edge 3, low from edge 4 onward.
  - Required: no pulse before edge 9. btn_level[0]=1 and btn_press[0]=1 at edge 9.
- Glitch:
  - Stimulus: btn_n[1] low for 3 cycles, then high.
  - Required: btn_level[1]=0 and no press or release pulses, ever.
- Release:
  - Stimulus: from PRESSED, btn_n[0] 0->1 at edge 0, held high.
  - Required: btn_level[0]=0 and btn_release[0]=1 at edge 5 only.
- Simultaneous events plus reset mid-count:
  - Stimulus: btn_n 11->00 at edge 0; rst=1 at edge 3 for 1 cycle; buttons held low.
  - Required: no pulses through edge 3. Both press pulses at edge 6 after rst deasserts (edge 4 = first post-reset sample, press at edge 9).
